// File: rtl/fx3_packet_sequencer_if.sv
// Bus bundle between the sample FIFO / FX3 GPIF side and the packet sequencer.
// The sequencer takes the slave view; the surrounding logic (or a bench) takes the master view.
interface fx3_packet_sequencer_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int LEVEL_WIDTH = 16
);
  logic                   enable;
  logic                   readData;
  logic [LEVEL_WIDTH-1:0] bufferLevel;
  logic [DATA_WIDTH-1:0]  bufferData;
  logic                   clearStatus;
  logic                   bufferRead;
  logic [DATA_WIDTH-1:0]  fx3Data;
  logic                   fx3isReading;
  logic                   packetEnd;
  logic                   underrun;
  logic                   aborted;
  logic [15:0]            packetCount;

  modport master (
    output enable, readData, bufferLevel, bufferData, clearStatus,
    input  bufferRead, fx3Data, fx3isReading, packetEnd, underrun, aborted, packetCount
  );

  modport slave (
    input  enable, readData, bufferLevel, bufferData, clearStatus,
    output bufferRead, fx3Data, fx3isReading, packetEnd, underrun, aborted, packetCount
  );
endinterface

// File: rtl/fx3_packet_sequencer.sv
// GPIF-II packet sequencer: on an FX3 read request with enough buffered samples,
// streams exactly one PACKET_WORDS-long packet from the show-ahead FIFO, then idles.
module fx3_packet_sequencer #(
  parameter int DATA_WIDTH   = 16,
  parameter int PACKET_WORDS = 8192,
  parameter int COUNT_WIDTH  = 14,
  parameter int LEVEL_WIDTH  = 16,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                  inclk,
  input  logic                  nReset,
  fx3_packet_sequencer_if.slave bus
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WAIT_REQUEST = 3'd1,
    WAIT_DATA    = 3'd2,
    SEND         = 3'd3,
    GAP          = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic                   read_data_q;
  logic [COUNT_WIDTH-1:0] word_q, word_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [DATA_WIDTH-1:0]  fx3_data_q, fx3_data_d;
  logic                   fx3_vld_q, fx3_vld_d;
  logic                   pkt_end_q, pkt_end_d;
  logic                   underrun_q, underrun_d;
  logic                   aborted_q, aborted_d;
  logic [15:0]            pkt_cnt_q, pkt_cnt_d;

  logic pop, fifo_empty, underrun_set, abort_set, pkt_inc;

  assign pop        = (state_q == SEND);
  assign fifo_empty = (bus.bufferLevel == '0);

  always_comb begin
    state_d      = state_q;
    word_d       = '0;
    gap_d        = '0;
    fx3_data_d   = fx3_data_q;
    fx3_vld_d    = 1'b0;
    pkt_end_d    = 1'b0;
    underrun_set = 1'b0;
    abort_set    = 1'b0;
    pkt_inc      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.enable) state_d = WAIT_REQUEST;
      end
      WAIT_REQUEST: begin
        if (!bus.enable)     state_d = IDLE;
        else if (read_data_q) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (!read_data_q)
          state_d = WAIT_REQUEST;
        else if (bus.bufferLevel >= LEVEL_WIDTH'(PACKET_WORDS))
          state_d = SEND;
      end
      SEND: begin
        // The word popped this cycle is always presented, even on abort.
        fx3_vld_d    = 1'b1;
        fx3_data_d   = fifo_empty ? '0 : bus.bufferData;
        underrun_set = fifo_empty;
        if (!read_data_q) begin
          abort_set = 1'b1;
          state_d   = WAIT_REQUEST;
        end else if (word_q == COUNT_WIDTH'(PACKET_WORDS - 1)) begin
          pkt_end_d = 1'b1;
          pkt_inc   = 1'b1;
          state_d   = GAP;
        end else begin
          word_d = word_q + COUNT_WIDTH'(1);
        end
      end
      GAP: begin
        // First GAP cycle still shows the last word on the bus, so the state
        // lasts one extra cycle to give GAP_CYCLES truly idle bus cycles.
        if (gap_q == GW'(GAP_CYCLES)) begin
          state_d = bus.enable ? WAIT_REQUEST : IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Status: a same-cycle set beats a clear; a same-cycle clear beats the increment.
    underrun_d = (underrun_q & ~bus.clearStatus) | underrun_set;
    aborted_d  = (aborted_q  & ~bus.clearStatus) | abort_set;
    pkt_cnt_d  = bus.clearStatus ? 16'd0 : (pkt_cnt_q + {15'd0, pkt_inc});
  end

  always_ff @(posedge inclk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      read_data_q <= 1'b0;
      word_q      <= '0;
      gap_q       <= '0;
      fx3_data_q  <= '0;
      fx3_vld_q   <= 1'b0;
      pkt_end_q   <= 1'b0;
      underrun_q  <= 1'b0;
      aborted_q   <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      read_data_q <= bus.readData;
      word_q      <= word_d;
      gap_q       <= gap_d;
      fx3_data_q  <= fx3_data_d;
      fx3_vld_q   <= fx3_vld_d;
      pkt_end_q   <= pkt_end_d;
      underrun_q  <= underrun_d;
      aborted_q   <= aborted_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign bus.bufferRead   = pop;
  assign bus.fx3Data      = fx3_data_q;
  assign bus.fx3isReading = fx3_vld_q;
  assign bus.packetEnd    = pkt_end_q;
  assign bus.underrun     = underrun_q;
  assign bus.aborted      = aborted_q;
  assign bus.packetCount  = pkt_cnt_q;

endmodule

// File: tb/tb_fx3_packet_sequencer.sv
// Scoreboard bench for fx3_packet_sequencer with 16-word packets and a modelled show-ahead FIFO.
module tb_fx3_packet_sequencer;

  typedef struct packed {
    logic [15:0] d;
    logic        last;
  } exp_t;

  logic inclk = 1'b0;
  logic nReset;

  fx3_packet_sequencer_if #(.DATA_WIDTH(16), .LEVEL_WIDTH(16)) bus ();

  fx3_packet_sequencer #(
    .DATA_WIDTH(16), .PACKET_WORDS(16), .COUNT_WIDTH(4),
    .LEVEL_WIDTH(16), .GAP_CYCLES(2)
  ) dut (
    .inclk (inclk),
    .nReset(nReset),
    .bus   (bus.slave)
  );

  always #5 inclk = ~inclk;

  int n_vec = 0;
  int n_err = 0;
  exp_t exp_q[$];
  exp_t e;

  // FIFO model: show-ahead, level optionally overridden to fake a stall.
  logic [15:0] mem [0:1023];
  int  wr_ptr = 0;
  int  rd_ptr = 0;
  bit  lvl_force = 1'b0;
  int  lvl_val = 0;
  bit  flush_req = 1'b0;

  assign bus.bufferLevel = lvl_force ? 16'(lvl_val) : 16'(wr_ptr - rd_ptr);
  assign bus.bufferData  = (wr_ptr != rd_ptr) ? mem[rd_ptr % 1024] : 16'hDEAD;

  always @(posedge inclk) begin
    if (flush_req) rd_ptr <= wr_ptr;
    else if (bus.bufferRead && bus.bufferLevel != 16'd0) rd_ptr <= rd_ptr + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  task automatic put(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr % 1024] = 16'(base + i);
      wr_ptr++;
    end
  endtask

  task automatic expect_words(input int base, input int n, input bit last_on_end);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{d: 16'(base + i), last: (last_on_end && i == n - 1)});
  endtask

  // Returns at the falling edge of the cycle in which word idx is being popped.
  task automatic wait_pop(input int idx, input string nm);
    int k;
    bit hit;
    k = 0;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge inclk);
      if (bus.bufferRead) begin
        if (k == idx) hit = 1'b1;
        else k++;
      end
    end
    chk(nm, 32'(hit), 32'd1);
  endtask

  task automatic wait_end(input string nm);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge inclk);
      if (bus.packetEnd) hit = 1'b1;
    end
    chk(nm, 32'(hit), 32'd1);
  endtask

  task automatic flush();
    @(negedge inclk);
    flush_req = 1'b1;
    @(negedge inclk);
    flush_req = 1'b0;
  endtask

  // Monitor: every valid bus word is matched against the head of the scoreboard.
  always @(negedge inclk) begin
    if (nReset === 1'b1 && bus.fx3isReading === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word act=%0h req=none", bus.fx3Data);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", 32'(bus.fx3Data), 32'(e.d));
        chk("word_end", 32'(bus.packetEnd), 32'(e.last));
      end
    end
  end

  initial begin
    int lat, r, g;
    bit seen;

    nReset = 1'b0;
    bus.enable = 1'b0;
    bus.readData = 1'b0;
    bus.clearStatus = 1'b0;
    repeat (3) @(negedge inclk);
    chk("rst_bufferRead", 32'(bus.bufferRead), 0);
    chk("rst_fx3isReading", 32'(bus.fx3isReading), 0);
    chk("rst_fx3Data", 32'(bus.fx3Data), 0);
    chk("rst_packetEnd", 32'(bus.packetEnd), 0);
    chk("rst_underrun", 32'(bus.underrun), 0);
    chk("rst_aborted", 32'(bus.aborted), 0);
    chk("rst_packetCount", 32'(bus.packetCount), 0);
    chk("rst_state", 32'(dut.state_q), 0);
    nReset = 1'b1;

    // Two back-to-back packets from a FIFO holding 0..31.
    bus.enable = 1'b1;
    put(0, 32);
    expect_words(0, 16, 1'b1);
    expect_words(16, 16, 1'b1);
    repeat (2) @(negedge inclk);
    bus.readData = 1'b1;
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge inclk);
      lat++;
      if (bus.fx3isReading) break;
    end
    chk("first_word_latency", 32'(lat), 32'd4);
    r = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge inclk);
      if (!bus.fx3isReading) break;
      r++;
    end
    chk("pkt1_len", 32'(r), 32'd16);
    g = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge inclk);
      if (bus.fx3isReading) break;
      g++;
    end
    chk("gap_at_least_5", 32'(g >= 5), 32'd1);
    r = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge inclk);
      if (!bus.fx3isReading) break;
      r++;
    end
    chk("pkt2_len", 32'(r), 32'd16);
    bus.readData = 1'b0;
    repeat (4) @(negedge inclk);
    chk("count_after_2", 32'(bus.packetCount), 32'd2);
    chk("no_underrun_1", 32'(bus.underrun), 0);
    chk("no_abort_1", 32'(bus.aborted), 0);

    // Level 10: must hold in WAIT_DATA; raising it to 16 starts the packet.
    bus.readData = 1'b1;
    put(100, 10);
    expect_words(100, 16, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge inclk);
      seen |= bus.bufferRead;
    end
    chk("short_level_no_read", 32'(seen), 0);
    chk("short_level_wait_data", 32'(dut.state_q), 32'd2);
    put(110, 6);
    @(negedge inclk);
    chk("start_read_edge1", 32'(bus.bufferRead), 1);
    @(negedge inclk);
    chk("start_valid_edge2", 32'(bus.fx3isReading), 1);
    wait_end("pkt3_end_seen");
    chk("count_after_3", 32'(bus.packetCount), 32'd3);

    // FIFO stalls at word 12: words 12..15 go out as 0 and the packet still completes.
    put(200, 16);
    expect_words(200, 12, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back('{d: 16'd0, last: (i == 3)});
    wait_pop(12, "stall_pop12_seen");
    lvl_force = 1'b1;
    lvl_val = 0;
    wait_end("pkt4_end_seen");
    chk("underrun_set", 32'(bus.underrun), 1);
    chk("count_after_4", 32'(bus.packetCount), 32'd4);
    @(negedge inclk);
    lvl_force = 1'b0;
    flush();

    // Request withdrawn after word 5: words 0..6 only, aborted, no count.
    put(300, 16);
    expect_words(300, 7, 1'b0);
    wait_pop(5, "abort_pop5_seen");
    bus.readData = 1'b0;
    repeat (6) @(negedge inclk);
    chk("aborted_set", 32'(bus.aborted), 1);
    chk("count_after_abort", 32'(bus.packetCount), 32'd4);
    chk("abort_no_read", 32'(bus.bufferRead), 0);
    chk("abort_state_wait_req", 32'(dut.state_q), 32'd1);
    flush();

    // clearStatus on the same cycle as the packet completes: count ends at 0.
    bus.readData = 1'b1;
    put(400, 16);
    expect_words(400, 16, 1'b1);
    wait_pop(15, "clr_pop15_seen");
    bus.clearStatus = 1'b1;
    @(negedge inclk);
    bus.clearStatus = 1'b0;
    chk("clear_end_seen", 32'(bus.packetEnd), 1);
    chk("clear_count", 32'(bus.packetCount), 0);
    chk("clear_underrun", 32'(bus.underrun), 0);
    chk("clear_aborted", 32'(bus.aborted), 0);

    // Asynchronous reset mid-packet.
    put(500, 16);
    expect_words(500, 5, 1'b0);
    wait_pop(5, "rst_pop5_seen");
    #2;
    nReset = 1'b0;
    #1;
    chk("mid_rst_fx3isReading", 32'(bus.fx3isReading), 0);
    chk("mid_rst_fx3Data", 32'(bus.fx3Data), 0);
    chk("mid_rst_bufferRead", 32'(bus.bufferRead), 0);
    chk("mid_rst_packetEnd", 32'(bus.packetEnd), 0);
    chk("mid_rst_packetCount", 32'(bus.packetCount), 0);
    chk("mid_rst_state", 32'(dut.state_q), 0);
    bus.readData = 1'b0;
    repeat (3) @(negedge inclk);
    nReset = 1'b1;
    repeat (5) @(negedge inclk);
    chk("no_resume_read", 32'(bus.bufferRead), 0);
    chk("no_resume_valid", 32'(bus.fx3isReading), 0);

    repeat (2) @(negedge inclk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
